// File: rtl/prediction_update_engine.sv
// Predictor table write-back engine: commit updates, ID/EX rollback undo, and saturating stat counters.
// Define PRED_STAT_DECAY_EN to replace the immediate clear_en request with a table-wide decay sweep.
module prediction_update_engine #(
    parameter int NUM_PRED   = 3,
    parameter int ADDR_WIDTH = 3,
    parameter int JSC_WIDTH  = 2,
    parameter int STAT_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             PL_stall,
    input  logic                             prediction_en,
    input  logic                             prediction_result,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [NUM_PRED*JSC_WIDTH-1:0]    index,
    input  logic [NUM_PRED*3-1:0]            trend_count,
    input  logic [NUM_PRED*STAT_WIDTH-1:0]   stat_count,
    input  logic                             rollback_en_id,
    input  logic                             prediction_result_id,
    input  logic [ADDR_WIDTH-1:0]            addr_id,
    input  logic [NUM_PRED*JSC_WIDTH-1:0]    index_id,
    input  logic                             rollback_en_ex,
    input  logic                             prediction_result_ex,
    input  logic [ADDR_WIDTH-1:0]            addr_ex,
    input  logic [NUM_PRED*JSC_WIDTH-1:0]    index_ex,
    output logic [NUM_PRED-1:0]              WR_en1,
    output logic [NUM_PRED-1:0]              WR_en2,
    output logic [ADDR_WIDTH-1:0]            WR_addr1,
    output logic [ADDR_WIDTH-1:0]            WR_addr2,
    output logic [NUM_PRED*JSC_WIDTH-1:0]    WR_index1,
    output logic [NUM_PRED*JSC_WIDTH-1:0]    WR_index2,
    output logic [NUM_PRED*3-1:0]            WR_trend1,
    output logic [NUM_PRED*3-1:0]            WR_trend2,
    output logic [NUM_PRED*STAT_WIDTH-1:0]   WR_stat1,
    output logic [NUM_PRED*STAT_WIDTH-1:0]   WR_stat2,
    output logic                             clear_en,
    output logic                             decay_busy,
    output logic [ADDR_WIDTH-1:0]            decay_addr
);
    // Stat sums carry two guard bits so the worst-case +/-2 delta never wraps before clamping.
    localparam int XW = STAT_WIDTH + 2;
    localparam logic signed [XW-1:0] STAT_MAX = {3'b000, {(STAT_WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] STAT_MIN = {3'b111, {(STAT_WIDTH-1){1'b0}}};
    localparam logic signed [XW-1:0] P1       = XW'(1);
    localparam logic signed [XW-1:0] M1       = {XW{1'b1}};
    localparam logic signed [XW-1:0] ZERO     = '0;
    localparam logic signed [3:0]    T_MAX    = 4'sd3;
    localparam logic signed [3:0]    T_MIN    = -4'sd3;

    logic [NUM_PRED*3-1:0]          trend_id, trend_ex;
    logic [NUM_PRED*STAT_WIDTH-1:0] stat_id, stat_ex;
    logic [NUM_PRED-1:0]            ovf_ch;
    logic                           overflow;

    function automatic logic signed [XW-1:0] ext_stat(input logic [STAT_WIDTH-1:0] s);
        return {{2{s[STAT_WIDTH-1]}}, s};
    endfunction

    function automatic logic [STAT_WIDTH-1:0] clamp_stat(input logic signed [XW-1:0] v);
        if (v > STAT_MAX) return STAT_MAX[STAT_WIDTH-1:0];
        if (v < STAT_MIN) return STAT_MIN[STAT_WIDTH-1:0];
        return v[STAT_WIDTH-1:0];
    endfunction

    function automatic logic out_of_range(input logic signed [XW-1:0] v);
        return (v > STAT_MAX) || (v < STAT_MIN);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trend_id <= '0;
            trend_ex <= '0;
            stat_id  <= '0;
            stat_ex  <= '0;
        end else if (!PL_stall) begin
            trend_ex <= trend_id;
            stat_ex  <= stat_id;
            trend_id <= trend_count;
            stat_id  <= stat_count;
        end
    end

    assign WR_addr1  = addr_id;
    assign WR_index1 = index_id;
    assign WR_trend1 = trend_id;
    assign WR_addr2  = rollback_en_ex ? addr_ex  : addr;
    assign WR_index2 = rollback_en_ex ? index_ex : index;

    for (genvar c = 0; c < NUM_PRED; c++) begin : g_ch
        logic                   fail, fail_id, fail_ex, conflict;
        logic signed [XW-1:0]   d_id, sum1, sum_cm, sum_rb, sum2;
        logic signed [3:0]      trend_sum;
        logic [2:0]             trend_cm;

        assign fail     = prediction_result    != index[c*JSC_WIDTH + JSC_WIDTH-1];
        assign fail_id  = prediction_result_id != index_id[c*JSC_WIDTH + JSC_WIDTH-1];
        assign fail_ex  = prediction_result_ex != index_ex[c*JSC_WIDTH + JSC_WIDTH-1];
        assign conflict = (addr_id == addr_ex) &&
                          (index_id[c*JSC_WIDTH +: JSC_WIDTH] == index_ex[c*JSC_WIDTH +: JSC_WIDTH]);

        assign d_id = fail_id ? P1 : M1;
        assign sum1 = ext_stat(stat_id[c*STAT_WIDTH +: STAT_WIDTH]) + d_id;

        assign WR_en1[c] = rollback_en_id && !conflict;
        assign WR_stat1[c*STAT_WIDTH +: STAT_WIDTH] = clamp_stat(sum1);

        assign trend_sum = {trend_count[c*3+2], trend_count[c*3 +: 3]} + (fail ? 4'sb1111 : 4'sb0001);
        assign trend_cm  = (trend_sum > T_MAX) ? 3'b011 :
                           (trend_sum < T_MIN) ? 3'b101 : trend_sum[2:0];

        // A conflicting ID entry was suppressed on port 1, so its undo is folded into the EX write.
        assign sum_cm = ext_stat(stat_count[c*STAT_WIDTH +: STAT_WIDTH]) + (fail ? M1 : P1);
        assign sum_rb = ext_stat(stat_ex[c*STAT_WIDTH +: STAT_WIDTH]) + (fail_ex ? P1 : M1) +
                        (conflict ? d_id : ZERO);
        assign sum2   = rollback_en_ex ? sum_rb : sum_cm;

        assign WR_en2[c] = prediction_en || rollback_en_ex;
        assign WR_trend2[c*3 +: 3] = rollback_en_ex ? trend_ex[c*3 +: 3] : trend_cm;
        assign WR_stat2[c*STAT_WIDTH +: STAT_WIDTH] = clamp_stat(sum2);

        assign ovf_ch[c] = (WR_en1[c] && out_of_range(sum1)) || (WR_en2[c] && out_of_range(sum2));
    end

    assign overflow = |ovf_ch;

`ifdef PRED_STAT_DECAY_EN
    // state   | meaning
    // S_IDLE  | no sweep, waiting for an overflow event
    // S_SWEEP | walking decay_addr over every table entry, one per cycle
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    logic [0:0] state;
    logic       pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            decay_addr <= '0;
            pending    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (overflow) begin
                        state      <= S_SWEEP;
                        decay_addr <= '0;
                    end
                end
                S_SWEEP: begin
                    if (decay_addr == LAST_ADDR) begin
                        decay_addr <= '0;
                        if (pending || overflow) pending <= 1'b0;
                        else                     state   <= S_IDLE;
                    end else begin
                        decay_addr <= decay_addr + ADDR_WIDTH'(1);
                        if (overflow) pending <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign decay_busy = (state == S_SWEEP);
    assign clear_en   = 1'b0;
`else
    assign clear_en   = overflow;
    assign decay_busy = 1'b0;
    assign decay_addr = '0;
`endif

endmodule

// File: tb/tb_prediction_update_engine.sv
// Randomized bench for prediction_update_engine against an integer-arithmetic reference model.
// Decay-sweep checks are active when PRED_STAT_DECAY_EN is defined.
module tb_prediction_update_engine;
    localparam int NP = 3;
    localparam int AW = 3;
    localparam int JW = 2;
    localparam int SW = 5;
    localparam int N_ENT = 1 << AW;
    localparam int SMAX = (1 << (SW-1)) - 1;
    localparam int SMIN = -(1 << (SW-1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic PL_stall = 1'b0, prediction_en = 1'b0, prediction_result = 1'b0;
    logic [AW-1:0] addr = '0, addr_id = '0, addr_ex = '0;
    logic [NP*JW-1:0] index = '0, index_id = '0, index_ex = '0;
    logic [NP*3-1:0] trend_count = '0;
    logic [NP*SW-1:0] stat_count = '0;
    logic rollback_en_id = 1'b0, prediction_result_id = 1'b0;
    logic rollback_en_ex = 1'b0, prediction_result_ex = 1'b0;

    logic [NP-1:0] WR_en1, WR_en2;
    logic [AW-1:0] WR_addr1, WR_addr2;
    logic [NP*JW-1:0] WR_index1, WR_index2;
    logic [NP*3-1:0] WR_trend1, WR_trend2;
    logic [NP*SW-1:0] WR_stat1, WR_stat2;
    logic clear_en, decay_busy;
    logic [AW-1:0] decay_addr;

    prediction_update_engine #(.NUM_PRED(NP), .ADDR_WIDTH(AW), .JSC_WIDTH(JW), .STAT_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n), .PL_stall(PL_stall),
        .prediction_en(prediction_en), .prediction_result(prediction_result),
        .addr(addr), .index(index), .trend_count(trend_count), .stat_count(stat_count),
        .rollback_en_id(rollback_en_id), .prediction_result_id(prediction_result_id),
        .addr_id(addr_id), .index_id(index_id),
        .rollback_en_ex(rollback_en_ex), .prediction_result_ex(prediction_result_ex),
        .addr_ex(addr_ex), .index_ex(index_ex),
        .WR_en1(WR_en1), .WR_en2(WR_en2), .WR_addr1(WR_addr1), .WR_addr2(WR_addr2),
        .WR_index1(WR_index1), .WR_index2(WR_index2), .WR_trend1(WR_trend1), .WR_trend2(WR_trend2),
        .WR_stat1(WR_stat1), .WR_stat2(WR_stat2),
        .clear_en(clear_en), .decay_busy(decay_busy), .decay_addr(decay_addr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: pipeline shadows as plain signed integers, sweep as cycles remaining.
    int m_tid[NP], m_sid[NP], m_tex[NP], m_sex[NP];
    int m_left = 0;
    bit m_pend = 1'b0;

    logic [NP-1:0] e_en1, e_en2;
    logic [63:0] e_trend1, e_trend2, e_stat1, e_stat2;
    bit e_ovf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fld(input logic [63:0] v, input int c, input int w, input bit sgn);
        longint u;
        u = longint'((v >> (c*w)) & ((64'd1 << w) - 64'd1));
        if (sgn && u >= (longint'(1) << (w-1))) u -= (longint'(1) << w);
        return int'(u);
    endfunction

    function automatic logic [63:0] pack(input int v, input int c, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return (64'(longint'(v)) & m) << (c*w);
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NP; c++) begin
            m_tid[c] = 0; m_sid[c] = 0; m_tex[c] = 0; m_sex[c] = 0;
        end
        m_left = 0;
        m_pend = 1'b0;
    endtask

    task automatic model_eval();
        bit f, fid, fex, cf;
        int did, dc, s1, s2, t2;
        e_en1 = '0; e_en2 = '0; e_ovf = 1'b0;
        e_trend1 = '0; e_trend2 = '0; e_stat1 = '0; e_stat2 = '0;
        for (int c = 0; c < NP; c++) begin
            f   = prediction_result    != fld(index,    c, JW, 1'b0) >= (1 << (JW-1));
            fid = prediction_result_id != fld(index_id, c, JW, 1'b0) >= (1 << (JW-1));
            fex = prediction_result_ex != fld(index_ex, c, JW, 1'b0) >= (1 << (JW-1));
            cf  = (addr_id == addr_ex) && (fld(index_id, c, JW, 1'b0) == fld(index_ex, c, JW, 1'b0));
            did = fid ? 1 : -1;
            e_en1[c] = rollback_en_id && !cf;
            s1 = m_sid[c] + did;
            e_stat1  |= pack(clampi(s1, SMIN, SMAX), c, SW);
            e_trend1 |= pack(m_tid[c], c, 3);
            if (e_en1[c] && (s1 > SMAX || s1 < SMIN)) e_ovf = 1'b1;
            e_en2[c] = prediction_en || rollback_en_ex;
            if (rollback_en_ex) begin
                t2 = m_tex[c];
                s2 = m_sex[c] + (fex ? 1 : -1) + (cf ? did : 0);
            end else begin
                dc = f ? -1 : 1;
                t2 = clampi(fld(trend_count, c, 3, 1'b1) + dc, -3, 3);
                s2 = fld(stat_count, c, SW, 1'b1) + dc;
            end
            e_trend2 |= pack(t2, c, 3);
            e_stat2  |= pack(clampi(s2, SMIN, SMAX), c, SW);
            if (e_en2[c] && (s2 > SMAX || s2 < SMIN)) e_ovf = 1'b1;
        end
    endtask

    task automatic model_clock();
        if (!PL_stall) begin
            for (int c = 0; c < NP; c++) begin
                m_tex[c] = m_tid[c];
                m_sex[c] = m_sid[c];
                m_tid[c] = fld(trend_count, c, 3, 1'b1);
                m_sid[c] = fld(stat_count, c, SW, 1'b1);
            end
        end
`ifdef PRED_STAT_DECAY_EN
        if (m_left > 0) begin
            if (e_ovf) m_pend = 1'b1;
            m_left--;
            if (m_left == 0 && m_pend) begin
                m_left = N_ENT;
                m_pend = 1'b0;
            end
        end else if (e_ovf) begin
            m_left = N_ENT;
        end
`endif
    endtask

    task automatic settle_and_check();
        #2;
        model_eval();
        check("wr_en1", WR_en1, e_en1);
        check("wr_en2", WR_en2, e_en2);
        check("wr_addr1", WR_addr1, addr_id);
        check("wr_index1", WR_index1, index_id);
        check("wr_addr2", WR_addr2, rollback_en_ex ? addr_ex : addr);
        check("wr_index2", WR_index2, rollback_en_ex ? index_ex : index);
        check("wr_trend1", WR_trend1, e_trend1);
        check("wr_trend2", WR_trend2, e_trend2);
        check("wr_stat1", WR_stat1, e_stat1);
        check("wr_stat2", WR_stat2, e_stat2);
`ifdef PRED_STAT_DECAY_EN
        check("clear_en", clear_en, 0);
        check("decay_busy", decay_busy, (m_left > 0) ? 1 : 0);
        check("decay_addr", decay_addr, (m_left > 0) ? (N_ENT - m_left) : 0);
`else
        check("clear_en", clear_en, e_ovf);
        check("decay_busy", decay_busy, 0);
        check("decay_addr", decay_addr, 0);
`endif
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic quiet();
        prediction_en = 1'b0; rollback_en_id = 1'b0; rollback_en_ex = 1'b0; PL_stall = 1'b0;
    endtask

    task automatic overflow_commit();
        quiet();
        prediction_en = 1'b1; prediction_result = 1'b1;
        index = 6'b10_10_10;
        stat_count = {5'd0, 5'd0, 5'd15};
        trend_count = '0;
    endtask

    initial begin
        int busy_cnt;
        int guard;
        model_reset();
        settle_and_check();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Commit with a mispredicted channel 0.
        quiet();
        prediction_en = 1'b1; prediction_result = 1'b1;
        index = 6'b11_10_01; trend_count = '0; stat_count = {5'd0, 5'd0, 5'd3};
        settle_and_check();
        check("commit_en2", WR_en2, 3'b111);
        check("commit_c0_stat", WR_stat2[4:0], 5'd2);
        check("commit_c0_trend", WR_trend2[2:0], 3'b111);
        clock_edge();

        // Correct commit on a saturated channel 2.
        quiet();
        prediction_en = 1'b1; prediction_result = 1'b1;
        index = 6'b10_00_00; stat_count = {5'd15, 5'd0, 5'd0}; trend_count = '0;
        settle_and_check();
        check("sat_c2_stat", WR_stat2[14:10], 5'd15);
`ifndef PRED_STAT_DECAY_EN
        check("sat_clear_en", clear_en, 1'b1);
`endif
        clock_edge();
`ifdef PRED_STAT_DECAY_EN
        check("sat_leaves_idle", decay_busy, 1'b1);
`endif

        // Dual rollback with a channel-1 conflict; EX c1 shadow loaded with stat 4.
        quiet();
        stat_count = {5'd0, 5'd4, 5'd0}; trend_count = 9'b000_010_000;
        settle_and_check(); clock_edge();
        stat_count = {5'd1, 5'd2, 5'd3}; trend_count = 9'b001_001_001;
        settle_and_check(); clock_edge();
        prediction_en = 1'b1; addr = 3'd2; prediction_result = 1'b0;
        rollback_en_id = 1'b1; rollback_en_ex = 1'b1;
        prediction_result_id = 1'b0; prediction_result_ex = 1'b0;
        addr_id = 3'd5; addr_ex = 3'd5;
        index_id = 6'b11_10_00; index_ex = 6'b01_10_01;
        settle_and_check();
        check("conflict_en1_c1", WR_en1[1], 1'b0);
        check("conflict_stat2_c1", WR_stat2[9:5], 5'd6);
        check("rb_ex_addr2", WR_addr2, 3'd5);
        clock_edge();

        // Stall freezes both shadow stages.
        quiet();
        trend_count = 9'b001_010_011; stat_count = '0;
        settle_and_check(); clock_edge();
        trend_count = 9'b110_101_100;
        settle_and_check(); clock_edge();
        PL_stall = 1'b1; rollback_en_ex = 1'b1;
        prediction_result_ex = 1'b0; index_ex = '0; addr_ex = 3'd1; addr_id = 3'd0;
        for (int i = 0; i < 3; i++) begin
            trend_count = 9'($urandom);
            settle_and_check();
            check("stall_id_trend", WR_trend1, 9'b110_101_100);
            check("stall_ex_trend", WR_trend2, 9'b001_010_011);
            clock_edge();
        end
        quiet();

`ifdef PRED_STAT_DECAY_EN
        // Second overflow mid-sweep queues exactly one restart.
        guard = 0;
        while (decay_busy && guard < 40) begin
            settle_and_check(); clock_edge(); guard++;
        end
        check("idle_before_sweep", decay_busy, 1'b0);
        overflow_commit();
        settle_and_check(); clock_edge();
        busy_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 4) overflow_commit(); else quiet();
            settle_and_check();
            if (i == 4) check("ovf_step_addr", decay_addr, 3'd4);
            if (decay_busy) busy_cnt++;
            clock_edge();
        end
        check("busy_run_len", busy_cnt, 16);
`endif

        // Reset in the middle of a sweep.
        overflow_commit();
        settle_and_check(); clock_edge();
        quiet();
        for (int i = 0; i < 3; i++) begin
            settle_and_check(); clock_edge();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", decay_busy, 1'b0);
        check("rst_addr", decay_addr, '0);
        check("rst_trend1", WR_trend1, '0);
        model_reset();
        settle_and_check();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            PL_stall = ($urandom % 5) == 0;
            prediction_en = $urandom % 2;
            prediction_result = $urandom % 2;
            addr = AW'($urandom);
            index = 6'($urandom);
            trend_count = 9'($urandom);
            stat_count = 15'($urandom);
            rollback_en_id = ($urandom % 3) == 0;
            rollback_en_ex = ($urandom % 3) == 0;
            prediction_result_id = $urandom % 2;
            prediction_result_ex = $urandom % 2;
            addr_id = AW'($urandom % 2);
            addr_ex = AW'($urandom % 2);
            index_id = 6'($urandom);
            index_ex = ($urandom % 2) ? index_id : 6'($urandom);
            settle_and_check();
            clock_edge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
